// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 exhaustive self-test controller.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam int unsigned N_PAT     = 32;

  // One MISR step: shift left, fold the polynomial in when the MSB
  // falls out, then inject the two response bits into the low end.
  function automatic logic [15:0] misr_next(input logic [15:0] s,
                                            input logic [1:0]  d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {14'b0, d};
  endfunction

endpackage

// File: rtl/c17_misr.sv
// 16-bit multiple-input signature register compacting {o1,o2} responses.
module c17_misr
  import c17_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [15:0] sig
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  // Next signature: reload seed on clear, otherwise compact when enabled.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end
  end

  // Signature register with synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/c17_bist_ctrl.sv
// Exhaustive BIST controller for c17: walks all 32 input patterns, captures
// {O1,O2} per pattern and compacts them into a MISR signature.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        o1,
  input  logic        o2,
  output logic [4:0]  pat,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [63:0] resp_vec
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LAST_PAT    = 5'(N_PAT - 1);

  state_e      state_q, state_d;
  logic [4:0]  pat_q,   pat_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [63:0] resp_q,  resp_d;
  logic        start_ok;
  logic        sample_en;

  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign sample_en = (state_q == SAMPLE);

  // FSM, settle counter, pattern counter and response capture.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          state_d = APPLY;
          pat_d   = '0;
          cnt_d   = '0;
          resp_d  = '0;
        end
      end
      APPLY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        resp_d[{pat_q, 1'b0} +: 2] = {o1, o2};
        // Last-pattern test precedes the increment so pat never wraps.
        if (pat_q == LAST_PAT) begin
          state_d = DONE;
        end else begin
          pat_d   = pat_q + 5'd1;
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  c17_misr u_misr (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (sample_en),
    .din ({o1, o2}),
    .sig (signature)
  );

  assign pat      = pat_q;
  assign resp_vec = resp_q;
  assign busy     = (state_q == APPLY) || (state_q == SAMPLE);
  assign done     = (state_q == DONE);
  assign pass     = done && (signature == GOLDEN_SIG);

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench for c17_bist_ctrl driving a behavioural c17 core.
module tb_c17_bist_ctrl;

  // Gate-level c17: I1..I5 map to N1,N2,N3,N6,N7.
  function automatic logic [1:0] c17_ref(input logic [4:0] p);
    logic n10, n11, n16, n19;
    n10 = ~(p[4] & p[2]);
    n11 = ~(p[2] & p[1]);
    n16 = ~(p[3] & n11);
    n19 = ~(n11 & p[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  function automatic logic [1:0] core_ref(input logic [4:0] p, input logic stuck);
    logic [1:0] r;
    r = c17_ref(p);
    if (stuck) r[0] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] sig_ref(input logic stuck);
    logic [15:0] s;
    logic [1:0]  r;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 32; i++) begin
      r  = core_ref(5'(i), stuck);
      fb = s[15];
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
      s[1:0] = s[1:0] ^ r;
    end
    return s;
  endfunction

  function automatic logic [63:0] resp_ref(input logic stuck);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[2*i +: 2] = core_ref(5'(i), stuck);
    return v;
  endfunction

  localparam logic [15:0] GOLD = sig_ref(1'b0);

  logic        clk = 1'b0;
  logic        rst, start, stuck;
  logic        o1, o2;
  logic [4:0]  pat;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [63:0] resp_vec;
  logic [1:0]  core_out;

  always #5 clk = ~clk;

  assign core_out = core_ref(pat, stuck);
  assign o1 = core_out[1];
  assign o2 = core_out[0];

  c17_bist_ctrl #(
    .SETTLE_CYCLES (2),
    .GOLDEN_SIG    (GOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .o1        (o1),
    .o2        (o2),
    .pat       (pat),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .resp_vec  (resp_vec)
  );

  typedef struct {
    logic [15:0] sig;
    logic [63:0] resp;
    logic        pass;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic stk);
    exp_t e;
    e.sig  = sig_ref(stk);
    e.resp = resp_ref(stk);
    e.pass = (e.sig == GOLD);
    sb.push_back(e);
  endtask

  // Monitor: on each rising done, pop the expected run result and compare.
  logic done_prev = 1'b0;
  int   bcnt      = 0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("run_signature", 64'(signature), 64'(e.sig));
        check("run_resp_vec", resp_vec, e.resp);
        check("run_pass", 64'(pass), 64'(e.pass));
        check("run_busy_cycles", 64'(bcnt), 64'd96);
      end
    end
    if (busy) bcnt++;
    else      bcnt = 0;
    done_prev = done;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_pat(input logic [4:0] v, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (pat != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (pat != v) check({tag, "_pat_timeout"}, 64'(pat), 64'(v));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pat"},  64'(pat),       64'd0);
    check({tag, "_busy"}, 64'(busy),      64'd0);
    check({tag, "_done"}, 64'(done),      64'd0);
    check({tag, "_pass"}, 64'(pass),      64'd0);
    check({tag, "_sig"},  64'(signature), 64'hFFFF);
    check({tag, "_resp"}, resp_vec,       64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stuck = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");

    // rst and start together: reset must win.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", 64'(busy), 64'd0);
    check("rst_wins_pat",  64'(pat),  64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Normal run against the good core.
    push_exp(1'b0);
    pulse_start();
    @(negedge clk);
    check("start_busy_rise", 64'(busy), 64'd1);
    wait_done("good");
    check("good_pair0",  64'(resp_vec[1:0]),   64'b00);
    check("good_pair31", 64'(resp_vec[63:62]), 64'b10);
    check("good_pass",   64'(pass),            64'd1);
    check("good_pat31",  64'(pat),             64'd31);
    check("good_busy_low", 64'(busy),          64'd0);

    // o2 stuck at 1: signature must miss golden.
    stuck = 1'b1;
    push_exp(1'b1);
    pulse_start();
    wait_done("stuck");
    check("stuck_sig_differs", 64'(signature != GOLD), 64'd1);
    check("stuck_pass_low",    64'(pass),              64'd0);
    stuck = 1'b0;

    // Restart from DONE clears done and rescans from pattern 0.
    push_exp(1'b0);
    pulse_start();
    @(negedge clk);
    check("restart_done_clr", 64'(done), 64'd0);
    check("restart_pat0",     64'(pat),  64'd0);
    check("restart_sig_seed", 64'(signature), 64'hFFFF);
    wait_done("restart");

    // start while busy is ignored.
    push_exp(1'b0);
    pulse_start();
    wait_pat(5'd5, "ignore");
    pulse_start();
    wait_done("ignore");

    // Mid-run reset at pattern 10 discards everything.
    pulse_start();
    wait_pat(5'd10, "abort");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_idle("abort");
    push_exp(1'b0);
    pulse_start();
    wait_done("after_abort");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
